serial_sub16: RTL and testbench
===============================

# serial_sub16

Bit-serial 16-bit subtractor computing `a - b` one bit per clock through a single full-adder cell, using two's complement (`a + ~b + 1`). It is the sequential, area-minimal subtract counterpart to the team's 16-bit ripple adder. It sits beside that adder in the datapath wherever a difference and borrow are needed and a 16-cycle latency is acceptable. Operands enter and results leave through valid/ready handshakes.

## Interface
Parameters:
- none; width is fixed at 16 by the package constant `SUB_W`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operands presented.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input 16: minuend, sampled on the accept edge.
- `b` input 16: subtrahend, sampled on the accept edge.
- `out_valid` output 1: result available; high only in DONE.
- `out_ready` input 1: consumer takes the result.
- `diff` output 16: `a - b` mod 2^16.
- `borrow` output 1: 1 when unsigned `a < b`; equals the inverted final carry.
- `zero`, `neg`, `ovf` output 1 each: flags, present only with `SERIAL_SUB_FLAGS_EN`.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:** `in_ready` = 1. On `in_valid & in_ready`:
  - load operand shift registers with `a` and `~b`;
  - set carry register to 1;
  - set bit counter to 0;
  - go to RUN.
- **RUN:** each cycle, the full adder takes the LSBs of both shift registers plus the carry register.
  - The sum bit shifts into `diff` from the MSB side (shift right).
  - Carry-out is written to the carry register.
  - Both operand registers shift right.
  - Counter increments.
  - The cycle that processes bit 15 (counter = 15) sets `borrow` to the inverted carry-out and moves to DONE.
- **DONE:** `out_valid` = 1. `diff` and `borrow` are held stable until `out_valid & out_ready`, then the FSM returns to IDLE.
- `diff` and `borrow` may change during RUN. Consumers sample them only while `out_valid` = 1.
- `in_valid` in RUN or DONE is ignored; operands are not buffered.
- Counter is 4 bits and is not allowed to wrap; the bit-15 condition forces the exit.

## Timing
- Reset values:
  - state IDLE
  - `in_ready` = 1
  - `out_valid` = 0
  - `diff` = 0x0000, `borrow` = 0
  - flags 0
  - counter 0, carry 0
- Latency: operands accepted at edge E0; `out_valid` rises after edge E16 (16 cycles).
- Throughput: at most one operation per 18 cycles with `out_ready` held high (accept, 16 RUN cycles, DONE handshake). The next accept happens in the IDLE cycle after the output handshake edge.
- `out_ready` low in DONE: the result is held indefinitely with no loss.
- `rst` asserted in any state: the next edge returns all registers to reset values. An in-flight operation is discarded and `out_valid` never pulses for it.
- `rst` and `in_valid` asserted together: reset wins, nothing is accepted.

## Configuration
- `SERIAL_SUB_FLAGS_EN` defined:
  - `a[15]` and `b[15]` are captured at accept.
  - `zero` = (`diff` == 0).
  - `neg` = `diff[15]`.
  - `ovf` = (`a[15]` != `b[15]`) & (`diff[15]` != `a[15]`), i.e. signed overflow.
  - Flags update with `borrow` on the bit-15 cycle and are held in DONE.
- Undefined: `zero`, `neg` and `ovf` ports and the sign registers are absent.

## Structure
- Shared package `sub_pkg`:
  - `SUB_W = 16`;
  - `CNT_W = 4`;
  - state enum `sub_state_t` {IDLE, RUN, DONE}.
- One sub-module: the existing `full_adder` cell, instantiated once as the serial bit slice. All other logic is inline.

## Test plan
- 0x0005 − 0x0003 → `diff` 0x0002, `borrow` 0; `out_valid` exactly 16 cycles after accept.
- 0x0000 − 0x0001 → `diff` 0xFFFF, `borrow` 1, `neg` 1.
- 0x8000 − 0x0001 → `diff` 0x7FFF, `borrow` 0, `ovf` 1; 0x1234 − 0x1234 → 0x0000, `zero` 1.
- `out_ready` held low 5 cycles in DONE → `diff`/`borrow` stable. A new `in_valid` during RUN or DONE is not accepted (`in_ready` = 0).
- `rst` pulsed on the 8th RUN cycle → next cycle is IDLE with `in_ready` 1, `out_valid` 0, and no result emitted.
- Back-to-back: 0xFFFF − 0x0001 then 0x0001 − 0xFFFF with `out_ready` = 1 → 0xFFFE/`borrow` 0, then 0x0002/`borrow` 1; second accept 18 cycles after the first.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants and state type for the bit-serial subtractor.
package sub_pkg;

    localparam int SUB_W = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, used as the serial bit slice of the subtractor.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational sum and carry of three input bits
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial 16-bit subtractor: a - b computed as a + ~b + 1, one bit per
// clock through a single full_adder, with valid/ready on both sides.
// Optional feature macro: SERIAL_SUB_FLAGS_EN adds zero/neg/ovf result flags.
module serial_sub16
    import sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUB_W-1:0] a,
    input  logic [SUB_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUB_W-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SUB_W - 1);

    sub_state_t       state;
    logic [SUB_W-1:0] a_sh;
    logic [SUB_W-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             sum_bit;
    logic             carry_out;
    logic [SUB_W-1:0] next_diff;

`ifdef SERIAL_SUB_FLAGS_EN
    logic a_sign;
    logic b_sign;
`endif

    full_adder u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (sum_bit),
        .cout (carry_out)
    );

    // Result register after this cycle's sum bit enters from the MSB side
    assign next_diff = {sum_bit, diff[SUB_W-1:1]};

    // Control FSM plus the serial datapath registers, all reset together
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            borrow    <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= ~b;
                        carry    <= 1'b1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
`ifdef SERIAL_SUB_FLAGS_EN
                        a_sign   <= a[SUB_W-1];
                        b_sign   <= b[SUB_W-1];
`endif
                    end
                end
                RUN: begin
                    diff  <= next_diff;
                    carry <= carry_out;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    if (cnt == LAST_BIT) begin
                        borrow    <= ~carry_out;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                        zero      <= (next_diff == '0);
                        neg       <= sum_bit;
                        ovf       <= (a_sign != b_sign) && (sum_bit != a_sign);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16: vector table plus multi-cycle
// sequences (held result, ignored operands, reset mid-run, back-to-back).
// Flag checks are compiled in only when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_sub16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
`ifdef SERIAL_SUB_FLAGS_EN
    logic        zero;
    logic        neg;
    logic        ovf;
`endif

    int errors;
    int checks;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expDiff;
        logic        expBorrow;
        logic        expZero;
        logic        expNeg;
        logic        expOvf;
    } vec_t;

    vec_t vecs[7];

    serial_sub16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Present operands for one cycle; inputs change only on the falling edge
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        checkOutput("in_ready_before_accept", {15'd0, in_ready}, 16'd1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count cycles after the accept edge until out_valid, bounded
    task automatic waitResult(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Check result fields against one table entry
    task automatic checkVector(input vec_t v, input string tag);
        checkOutput({tag, "_diff"}, diff, v.expDiff);
        checkOutput({tag, "_borrow"}, {15'd0, borrow}, {15'd0, v.expBorrow});
`ifdef SERIAL_SUB_FLAGS_EN
        checkOutput({tag, "_zero"}, {15'd0, zero}, {15'd0, v.expZero});
        checkOutput({tag, "_neg"}, {15'd0, neg}, {15'd0, v.expNeg});
        checkOutput({tag, "_ovf"}, {15'd0, ovf}, {15'd0, v.expOvf});
`endif
    endtask

    // Consume the result with out_ready for one edge, then confirm IDLE
    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid_after_take", {15'd0, out_valid}, 16'd0);
        checkOutput("in_ready_after_take", {15'd0, in_ready}, 16'd1);
    endtask

    // Main test sequence
    initial begin
        int   cyc;
        int   seen;
        logic [15:0] held;
        logic        heldBorrow;

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_in_ready", {15'd0, in_ready}, 16'd1);
        checkOutput("reset_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("reset_diff", diff, 16'h0000);
        checkOutput("reset_borrow", {15'd0, borrow}, 16'd0);
`ifdef SERIAL_SUB_FLAGS_EN
        checkOutput("reset_flags", {13'd0, zero, neg, ovf}, 16'd0);
`endif

        // Table-driven vectors, one at a time with a 16-cycle latency check
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            waitResult(cyc);
            checkOutput($sformatf("vec%0d_latency", i), 16'(cyc), 16'd16);
            checkVector(vecs[i], $sformatf("vec%0d", i));
            handshake();
        end

        // Held result: out_ready low 5 cycles, new operands offered in RUN and DONE
        applyStimulus(16'h0005, 16'h0003);
        repeat (4) @(negedge clk);
        a        = 16'hAAAA;
        b        = 16'h1111;
        in_valid = 1'b1;
        checkOutput("run_in_ready_low", {15'd0, in_ready}, 16'd0);
        waitResult(cyc);
        checkOutput("hold_latency", 16'(cyc), 16'd12);
        held       = diff;
        heldBorrow = borrow;
        checkOutput("hold_first_diff", held, 16'h0002);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", {15'd0, out_valid}, 16'd1);
            checkOutput("hold_in_ready_low", {15'd0, in_ready}, 16'd0);
            checkOutput("hold_diff", diff, 16'h0002);
            checkOutput("hold_borrow", {15'd0, borrow}, {15'd0, heldBorrow});
        end
        in_valid = 1'b0;
        handshake();

        // Reset on the 8th RUN cycle discards the operation
        applyStimulus(16'h0005, 16'h0003);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready", {15'd0, in_ready}, 16'd1);
        checkOutput("midrst_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("midrst_diff", diff, 16'h0000);
        seen = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("midrst_no_result", 16'(seen), 16'd0);

        // Reset together with in_valid: nothing accepted
        a        = 16'h0009;
        b        = 16'h0001;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("rstvalid_in_ready", {15'd0, in_ready}, 16'd1);
        seen = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("rstvalid_no_result", 16'(seen), 16'd0);

        // Back-to-back with out_ready held high: second accept 18 cycles later
        @(negedge clk);
        out_ready = 1'b1;
        a         = 16'hFFFF;
        b         = 16'h0001;
        in_valid  = 1'b1;
        checkOutput("b2b_in_ready", {15'd0, in_ready}, 16'd1);
        @(negedge clk);
        a = 16'h0001;
        b = 16'hFFFF;
        waitResult(cyc);
        checkOutput("b2b_first_latency", 16'(cyc), 16'd16);
        checkOutput("b2b_first_diff", diff, 16'hFFFE);
        checkOutput("b2b_first_borrow", {15'd0, borrow}, 16'd0);
        while (!in_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("b2b_second_accept", 16'(cyc + 1), 16'd18);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("b2b_accepted", {15'd0, in_ready}, 16'd0);
        waitResult(cyc);
        checkOutput("b2b_second_latency", 16'(cyc), 16'd16);
        checkOutput("b2b_second_diff", diff, 16'h0002);
        checkOutput("b2b_second_borrow", {15'd0, borrow}, 16'd1);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("b2b_done_out_valid", {15'd0, out_valid}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
